// File: rtl/audio_ctrl_pkg.sv
// Shared types for the flash audio playback path: keyboard command codes,
// the play-state encoding and the direction flag values.
package audio_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_PLAY    = 3'd1,
        CMD_PAUSE   = 3'd2,
        CMD_FWD     = 3'd3,
        CMD_BWD     = 3'd4,
        CMD_RESTART = 3'd5,
        CMD_FASTER  = 3'd6,
        CMD_SLOWER  = 3'd7
    } playback_cmd_t;

    typedef enum logic {
        PAUSED  = 1'b0,
        PLAYING = 1'b1
    } play_state_t;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_BWD = 1'b0;

endpackage

// File: rtl/sample_rate_divider.sv
// Adjustable sample-rate divider: holds the saturating divider value and the
// countdown that emits a one-cycle tick every div_value cycles while running.
module sample_rate_divider #(
    parameter int DIV_W       = 16,
    parameter int DIV_DEFAULT = 2272,
    parameter int DIV_MIN     = 1136,
    parameter int DIV_MAX     = 4544,
    parameter int DIV_STEP    = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic             faster,
    input  logic             slower,
    output logic             tick,
    output logic [DIV_W-1:0] div_value
);

    localparam logic [DIV_W:0]   MIN_X   = (DIV_W+1)'(DIV_MIN);
    localparam logic [DIV_W:0]   MAX_X   = (DIV_W+1)'(DIV_MAX);
    localparam logic [DIV_W:0]   STEP_X  = (DIV_W+1)'(DIV_STEP);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic [DIV_W:0]   dec, inc;
    logic [DIV_W-1:0] reload;

    // One extra bit so the step can never wrap before saturation is applied.
    assign dec    = {1'b0, div_q} - STEP_X;
    assign inc    = {1'b0, div_q} + STEP_X;
    assign reload = div_q - DIV_W'(1);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        div_d = div_q;
        if (faster) begin
            div_d = (dec[DIV_W] || dec < MIN_X) ? MIN_X[DIV_W-1:0] : dec[DIV_W-1:0];
        end else if (slower) begin
            div_d = (inc > MAX_X) ? MAX_X[DIV_W-1:0] : inc[DIV_W-1:0];
        end
    end

    // The tick flop is set on the edge leaving count 1, so the registered
    // pulse lines up with the cycle in which the counter reads zero.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (load) begin
            count_d = reload;
        end else if (run) begin
            if (count_q == '0) begin
                count_d = reload;
            end else begin
                count_d = count_q - DIV_W'(1);
                tick_d  = (count_q == DIV_W'(1));
            end
        end
    end

    // NOTE: reset is asynchronous and active-low, so it is in the sensitivity list rather than sampled on clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= DEF_DIV;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            div_q   <= div_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick      = tick_q;
    assign div_value = div_q;

endmodule

// File: rtl/audio_playback_ctrl.sv
// Playback scheduler: play/pause FSM, sample trigger via the rate divider,
// and the wrapping flash word address with direction and restart handling.
module audio_playback_ctrl
    import audio_ctrl_pkg::*;
#(
    parameter int                ADDR_W      = 23,
    parameter logic [ADDR_W-1:0] START_ADDR  = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR    = 23'h07FFFF,
    parameter int                DIV_W       = 16,
    parameter int                DIV_DEFAULT = 2272,
    parameter int                DIV_MIN     = 1136,
    parameter int                DIV_MAX     = 4544,
    parameter int                DIV_STEP    = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd,
    input  logic              address_change,
    output logic              startsamplenow,
    output logic              pause,
    output logic [ADDR_W-1:0] flsh_address,
    output logic              direction,
    output logic [DIV_W-1:0]  div_value
);

    playback_cmd_t cmd_e;
    logic is_play, is_pause, is_fwd, is_bwd, is_restart, is_faster, is_slower;

    assign cmd_e      = playback_cmd_t'(cmd);
    assign is_play    = cmd_valid && (cmd_e == CMD_PLAY);
    assign is_pause   = cmd_valid && (cmd_e == CMD_PAUSE);
    assign is_fwd     = cmd_valid && (cmd_e == CMD_FWD);
    assign is_bwd     = cmd_valid && (cmd_e == CMD_BWD);
    assign is_restart = cmd_valid && (cmd_e == CMD_RESTART);
    assign is_faster  = cmd_valid && (cmd_e == CMD_FASTER);
    assign is_slower  = cmd_valid && (cmd_e == CMD_SLOWER);

    play_state_t state_q, state_d;
    logic        load;
    logic        run;
    logic        pause_q;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            PAUSED: begin
                if (is_play) begin
                    state_d = PLAYING;
                    load    = 1'b1;
                end
            end
            PLAYING: begin
                if (is_pause) begin
                    state_d = PAUSED;
                end
            end
            default: state_d = PAUSED;
        endcase
    end

    assign run = (state_q == PLAYING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAUSED;
            pause_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pause_q <= (state_d == PAUSED);
        end
    end

    sample_rate_divider #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT),
        .DIV_MIN     (DIV_MIN),
        .DIV_MAX     (DIV_MAX),
        .DIV_STEP    (DIV_STEP)
    ) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .load      (load),
        .faster    (is_faster),
        .slower    (is_slower),
        .tick      (startsamplenow),
        .div_value (div_value)
    );

    logic              direction_q, direction_d;
    logic              restart_pending_q, restart_pending_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // The address step reads direction and restart_pending as registered, so
    // a command in the same cycle as a pulse only affects the following pulse.
    always_comb begin
        addr_d = addr_q;
        if (address_change) begin
            if (restart_pending_q) begin
                addr_d = (direction_q == DIR_FWD) ? START_ADDR : END_ADDR;
            end else if (direction_q == DIR_FWD) begin
                addr_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_W'(1);
            end else begin
                addr_d = (addr_q == START_ADDR) ? END_ADDR : addr_q - ADDR_W'(1);
            end
        end
    end

    always_comb begin
        direction_d = direction_q;
        if (is_fwd) begin
            direction_d = DIR_FWD;
        end else if (is_bwd) begin
            direction_d = DIR_BWD;
        end
    end

    assign restart_pending_d = (restart_pending_q && !address_change) || is_restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q            <= START_ADDR;
            direction_q       <= DIR_FWD;
            restart_pending_q <= 1'b0;
        end else begin
            addr_q            <= addr_d;
            direction_q       <= direction_d;
            restart_pending_q <= restart_pending_d;
        end
    end

    assign pause        = pause_q;
    assign flsh_address = addr_q;
    assign direction    = direction_q;

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Scoreboard bench for audio_playback_ctrl: stimulus pushes hand-computed
// expectations into queues, a negedge monitor pops and compares them.
module tb_audio_playback_ctrl;
    import audio_ctrl_pkg::*;

    localparam logic [22:0] START_A = 23'h10;
    localparam logic [22:0] END_A   = 23'h13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic        address_change = 1'b0;
    logic        startsamplenow;
    logic        pause;
    logic [22:0] flsh_address;
    logic        direction;
    logic [15:0] div_value;

    audio_playback_ctrl #(
        .ADDR_W      (23),
        .START_ADDR  (START_A),
        .END_ADDR    (END_A),
        .DIV_W       (16),
        .DIV_DEFAULT (8),
        .DIV_MIN     (4),
        .DIV_MAX     (12),
        .DIV_STEP    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd            (cmd),
        .address_change (address_change),
        .startsamplenow (startsamplenow),
        .pause          (pause),
        .flsh_address   (flsh_address),
        .direction      (direction),
        .div_value      (div_value)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int          tick_q[$];
    logic [22:0] addr_q[$];
    logic [15:0] div_q[$];
    logic        pause_q[$];
    logic        dir_q[$];

    logic ac_d = 1'b0, rate_d = 1'b0, ps_d = 1'b0, dir_d = 1'b0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        ac_d   <= address_change;
        rate_d <= cmd_valid && (cmd == CMD_FASTER || cmd == CMD_SLOWER);
        ps_d   <= cmd_valid && (cmd == CMD_PLAY || cmd == CMD_PAUSE);
        dir_d  <= cmd_valid && (cmd == CMD_FWD || cmd == CMD_BWD);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: updates the held expectations from the queues and compares.
    initial begin : monitor
        logic [22:0] addr_exp;
        logic [15:0] div_exp;
        logic        pause_exp, dir_exp, tick_exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                addr_exp  = START_A;
                div_exp   = 16'd8;
                pause_exp = 1'b1;
                dir_exp   = 1'b1;
            end else begin
                if (ac_d) begin
                    if (addr_q.size() > 0) addr_exp = addr_q.pop_front();
                    else check("addr_q_underflow", addr_q.size(), 1);
                end
                if (rate_d) begin
                    if (div_q.size() > 0) div_exp = div_q.pop_front();
                    else check("div_q_underflow", div_q.size(), 1);
                end
                if (ps_d) begin
                    if (pause_q.size() > 0) pause_exp = pause_q.pop_front();
                    else check("pause_q_underflow", pause_q.size(), 1);
                end
                if (dir_d) begin
                    if (dir_q.size() > 0) dir_exp = dir_q.pop_front();
                    else check("dir_q_underflow", dir_q.size(), 1);
                end
            end
            check("flsh_address", flsh_address, addr_exp);
            check("div_value", div_value, div_exp);
            check("pause", pause, pause_exp);
            check("direction", direction, dir_exp);
            tick_exp = rst_n && tick_q.size() > 0 && tick_q[0] == cyc;
            if (tick_exp) void'(tick_q.pop_front());
            check("startsamplenow", startsamplenow, tick_exp);
        end
    end

    task automatic step(input logic v, input logic [2:0] c, input logic ac);
        cmd_valid      = v;
        cmd            = c;
        address_change = ac;
        @(posedge clk);
        #1;
        cmd_valid      = 1'b0;
        cmd            = 3'd0;
        address_change = 1'b0;
    endtask

    task automatic idle_until(input int target);
        while (cyc < target) step(1'b0, CMD_NONE, 1'b0);
    endtask

    task automatic pulse(input logic [22:0] exp_addr);
        addr_q.push_back(exp_addr);
        step(1'b0, CMD_NONE, 1'b1);
    endtask

    initial begin : watchdog
        #100000;
        miscompares++;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int p;
        int q;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, CMD_NONE, 1'b0);

        // Tick timing, no-op PLAY, saturating rate changes, PAUSE at count 3.
        p = cyc;
        foreach (tick_q[i]) tick_q.delete(i);
        tick_q.push_back(p + 8);
        tick_q.push_back(p + 16);
        tick_q.push_back(p + 24);
        tick_q.push_back(p + 32);
        tick_q.push_back(p + 36);
        tick_q.push_back(p + 40);
        tick_q.push_back(p + 44);
        tick_q.push_back(p + 48);
        tick_q.push_back(p + 60);
        pause_q.push_back(1'b0);
        step(1'b1, CMD_PLAY, 1'b0);
        idle_until(p + 10);
        pause_q.push_back(1'b0);
        step(1'b1, CMD_PLAY, 1'b0);
        idle_until(p + 25);
        div_q.push_back(16'd4); step(1'b1, CMD_FASTER, 1'b0);
        div_q.push_back(16'd4); step(1'b1, CMD_FASTER, 1'b0);
        div_q.push_back(16'd4); step(1'b1, CMD_FASTER, 1'b0);
        idle_until(p + 45);
        div_q.push_back(16'd8);  step(1'b1, CMD_SLOWER, 1'b0);
        div_q.push_back(16'd12); step(1'b1, CMD_SLOWER, 1'b0);
        div_q.push_back(16'd12); step(1'b1, CMD_SLOWER, 1'b0);
        idle_until(p + 69);
        pause_q.push_back(1'b1);
        step(1'b1, CMD_PAUSE, 1'b0);
        idle_until(p + 85);

        // Address walk while paused: forward wrap, backward wrap.
        pulse(23'h11); pulse(23'h12); pulse(23'h13); pulse(23'h10); pulse(23'h11);
        dir_q.push_back(1'b0); step(1'b1, CMD_BWD, 1'b0);
        pulse(23'h10); pulse(23'h13); pulse(23'h12);
        dir_q.push_back(1'b1); step(1'b1, CMD_FWD, 1'b0);

        // Double RESTART collapses; address holds until the next pulse.
        step(1'b1, CMD_RESTART, 1'b0);
        step(1'b1, CMD_RESTART, 1'b0);
        repeat (20) step(1'b0, CMD_NONE, 1'b0);
        pulse(23'h10); pulse(23'h11);

        // RESTART in the same cycle as a pulse applies at the following pulse.
        addr_q.push_back(23'h12);
        step(1'b1, CMD_RESTART, 1'b1);
        pulse(23'h10);

        // Direction change after RESTART retargets the pending load to END.
        step(1'b1, CMD_RESTART, 1'b0);
        dir_q.push_back(1'b0); step(1'b1, CMD_BWD, 1'b0);
        pulse(23'h13); pulse(23'h12);
        dir_q.push_back(1'b1); step(1'b1, CMD_FWD, 1'b0);
        pause_q.push_back(1'b1); step(1'b1, CMD_PAUSE, 1'b0);
        repeat (4) step(1'b0, CMD_NONE, 1'b0);

        // Play at div 12, then asynchronous reset mid-count.
        q = cyc;
        tick_q.push_back(q + 12);
        tick_q.push_back(q + 24);
        pause_q.push_back(1'b0);
        step(1'b1, CMD_PLAY, 1'b0);
        dir_q.push_back(1'b0); step(1'b1, CMD_BWD, 1'b0);
        pulse(23'h11);
        idle_until(q + 30);
        rst_n = 1'b0;
        repeat (3) step(1'b0, CMD_NONE, 1'b0);
        rst_n = 1'b1;
        repeat (20) step(1'b0, CMD_NONE, 1'b0);

        check("tick_q_drained", tick_q.size(), 0);
        check("addr_q_drained", addr_q.size(), 0);
        check("div_q_drained", div_q.size(), 0);
        check("pause_q_drained", pause_q.size(), 0);
        check("dir_q_drained", dir_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
